// File: rtl/issue_sched_if.sv
// Issue-queue handshake bundle between decode (master) and the issue
// scheduler queue (slave).
//   in_*      : up to two decoded instructions per cycle, [1] older, [0] younger
//   in_ready  : queue can take two entries this cycle
//   out_*     : issued instructions, [1] = queue head, [0] = head+1
//   out_ready : downstream consumes everything presented this cycle
//   occupancy : current entry count
interface issue_sched_if #(
  parameter int PTR_W = 3
);
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic [1:0][4:0]  in_rdst;
  logic [1:0][4:0]  in_ra1;
  logic [1:0][4:0]  in_ra2;
  logic [1:0]       in_branch;
  logic [1:0]       in_mem;
  logic             in_ready;

  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_instr;
  logic [1:0][4:0]  out_rdst;
  logic [1:0][4:0]  out_ra1;
  logic [1:0][4:0]  out_ra2;
  logic [1:0]       out_branch;
  logic [1:0]       out_mem;
  logic             out_ready;
  logic [PTR_W:0]   occupancy;

  modport master (
    output in_valid, in_pc, in_instr, in_rdst, in_ra1, in_ra2, in_branch, in_mem,
    output out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_rdst, out_ra1, out_ra2,
    input  out_branch, out_mem, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_rdst, in_ra1, in_ra2, in_branch, in_mem,
    input  out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_rdst, out_ra1, out_ra2,
    output out_branch, out_mem, occupancy
  );
endinterface

// File: rtl/issue_sched_queue.sv
// Dual-issue instruction queue and issue scheduler.
// Circular FIFO of DEPTH decoded instructions; issues one or two per cycle
// in program order, pairing only when RAW, memory-port and branch/delay-slot
// rules allow.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous discard of all queued entries
//   sq         : push/issue bundle (slave side), see issue_sched_if

// Per-slot output stage: zeroes an issue slot that is not valid.
module issue_sched_slot #(
  parameter int W = 81
) (
  input  logic         vld,
  input  logic [W-1:0] ent_i,
  output logic [W-1:0] ent_o
);
  assign ent_o = vld ? ent_i : '0;
endmodule

module issue_sched_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  issue_sched_if.slave   sq
);
  localparam int CW = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rdst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        branch;
    logic        mem;
  } entry_t;

  entry_t ram [DEPTH];

  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [CW-1:0]    count;
  logic [PTR_W-1:0] push_n, pop_n;
  logic             in_ready;
  logic [1:0]       issue_v;
  entry_t           h_e, n_e, wr_first;
  entry_t [1:0]     in_e, slot_in, slot_out;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign h_e     = ram[head];
  assign n_e     = ram[head_p1];

  // Registered count only; a same-cycle pop never opens space.
  assign in_ready = (count <= CW'(DEPTH - 2));

  for (genvar s = 0; s < 2; s++) begin : g_in
    assign in_e[s] = '{pc: sq.in_pc[s], instr: sq.in_instr[s], rdst: sq.in_rdst[s],
                       ra1: sq.in_ra1[s], ra2: sq.in_ra2[s],
                       branch: sq.in_branch[s], mem: sq.in_mem[s]};
  end

  // Compaction: a lone slot [0] push lands at tail just like a lone slot [1].
  assign wr_first = sq.in_valid[1] ? in_e[1] : in_e[0];
  assign push_n   = in_ready ? (PTR_W'(sq.in_valid[1]) + PTR_W'(sq.in_valid[0])) : '0;
  assign pop_n    = sq.out_ready ? (PTR_W'(issue_v[1]) + PTR_W'(issue_v[0])) : '0;

  // Issue decision. A branch at the head never goes alone: it waits for its
  // delay slot and then always pairs with it, bypassing the hazard checks.
  always_comb begin
    issue_v = 2'b00;
    if (count != '0) begin
      if (h_e.branch) begin
        if (count >= CW'(2)) issue_v = 2'b11;
      end else if (count >= CW'(2) && !n_e.branch && !(h_e.mem && n_e.mem) &&
                   !(h_e.rdst != '0 && (h_e.rdst == n_e.ra1 || h_e.rdst == n_e.ra2))) begin
        issue_v = 2'b11;
      end else begin
        issue_v = 2'b10;
      end
    end
  end

  // Storage has no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (in_ready && !flush) begin
      if (|sq.in_valid) ram[tail]    <= wr_first;
      if (&sq.in_valid) ram[tail_p1] <= in_e[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n;
      tail  <= tail + push_n;
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign slot_in[1] = h_e;
  assign slot_in[0] = n_e;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    issue_sched_slot #(.W($bits(entry_t))) u_slot (
      .vld   (issue_v[s]),
      .ent_i (slot_in[s]),
      .ent_o (slot_out[s])
    );
    assign sq.out_pc[s]     = slot_out[s].pc;
    assign sq.out_instr[s]  = slot_out[s].instr;
    assign sq.out_rdst[s]   = slot_out[s].rdst;
    assign sq.out_ra1[s]    = slot_out[s].ra1;
    assign sq.out_ra2[s]    = slot_out[s].ra2;
    assign sq.out_branch[s] = slot_out[s].branch;
    assign sq.out_mem[s]    = slot_out[s].mem;
  end

  assign sq.out_valid = issue_v;
  assign sq.in_ready  = in_ready;
  assign sq.occupancy = count;
endmodule

// File: tb/tb_issue_sched_queue.sv
module tb_issue_sched_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rdst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        br;
    logic        mem;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  issue_sched_if #(.PTR_W(PTR_W)) bus ();

  issue_sched_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .sq    (bus)
  );

  always #5 clk = ~clk;

  ent_t ref_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(int pc, int rd, int a1, int a2, bit br, bit mem);
    ent_t e;
    e.pc    = 32'(pc);
    e.rdst  = 5'(rd);
    e.ra1   = 5'(a1);
    e.ra2   = 5'(a2);
    e.br    = br;
    e.mem   = mem;
    e.instr = {6'h00, 5'(a1), 5'(a2), 5'(rd), 5'h00, 6'h21};
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(int'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
  endfunction

  // How many instructions the pairing rules allow to leave this cycle.
  function automatic int exp_issue();
    if (ref_q.size() == 0) return 0;
    if (ref_q[0].br) return (ref_q.size() >= 2) ? 2 : 0;
    if (ref_q.size() < 2) return 1;
    if (ref_q[1].br) return 1;
    if (ref_q[0].mem && ref_q[1].mem) return 1;
    if (ref_q[0].rdst != 0 && (ref_q[0].rdst == ref_q[1].ra1 || ref_q[0].rdst == ref_q[1].ra2))
      return 1;
    return 2;
  endfunction

  // Monitor: compares presented outputs against the reference queue, then
  // retires whatever downstream accepts at the coming edge.
  initial begin : mon
    int         ni;
    int         k;
    ent_t       e;
    logic [1:0] ev;
    forever begin
      @(negedge clk);
      ni = exp_issue();
      ev = (ni == 2) ? 2'b11 : (ni == 1) ? 2'b10 : 2'b00;
      chk("occupancy", 64'(bus.occupancy), 64'(ref_q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(ref_q.size() <= DEPTH - 2));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      for (int s = 0; s < 2; s++) begin
        k = 1 - s;
        if (s < ni) e = ref_q[s];
        else e = mk(0, 0, 0, 0, 1'b0, 1'b0);
        if (s >= ni) e.instr = '0;
        chk($sformatf("out_pc[%0d]", k), 64'(bus.out_pc[k]), 64'(e.pc));
        chk($sformatf("out_instr[%0d]", k), 64'(bus.out_instr[k]), 64'(e.instr));
        chk($sformatf("out_rdst[%0d]", k), 64'(bus.out_rdst[k]), 64'(e.rdst));
        chk($sformatf("out_ra[%0d]", k), 64'({bus.out_ra1[k], bus.out_ra2[k]}), 64'({e.ra1, e.ra2}));
        chk($sformatf("out_flags[%0d]", k), 64'({bus.out_branch[k], bus.out_mem[k]}), 64'({e.br, e.mem}));
      end
      if (bus.out_ready && !reset)
        repeat (ni) void'(ref_q.pop_front());
    end
  end

  // Driver: called just after a rising edge; applies inputs for the next edge
  // and commits accepted pushes to the reference queue at that edge.
  task automatic step(logic [1:0] v, ent_t e1, ent_t e0, logic ordy, logic fl, logic rs);
    if (v != 2'b00 && !fl && !rs) chk("push_legal", 64'(bus.in_ready), 64'(1));
    reset          = rs;
    flush          = fl;
    bus.in_valid   = v;
    bus.in_pc      = {e1.pc, e0.pc};
    bus.in_instr   = {e1.instr, e0.instr};
    bus.in_rdst    = {e1.rdst, e0.rdst};
    bus.in_ra1     = {e1.ra1, e0.ra1};
    bus.in_ra2     = {e1.ra2, e0.ra2};
    bus.in_branch  = {e1.br, e0.br};
    bus.in_mem     = {e1.mem, e0.mem};
    bus.out_ready  = ordy;
    if (rs) ref_q.delete();
    @(posedge clk);
    if (fl || rs) ref_q.delete();
    else begin
      if (v[1]) ref_q.push_back(e1);
      if (v[0]) ref_q.push_back(e0);
    end
    #1;
  endtask

  task automatic idle(logic ordy, int n);
    ent_t z;
    z = mk(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (n) step(2'b00, z, z, ordy, 1'b0, 1'b0);
  endtask

  initial begin : main
    ent_t       z, a, b;
    logic [1:0] v;
    z = mk(0, 0, 0, 0, 1'b0, 1'b0);
    bus.in_valid  = '0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.in_rdst   = '0;
    bus.in_ra1    = '0;
    bus.in_ra2    = '0;
    bus.in_branch = '0;
    bus.in_mem    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: RAW on $3 keeps the pair apart
    step(2'b11, mk(32'h100, 3, 1, 2, 0, 0), mk(32'h104, 5, 3, 4, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);
    // 2: independent pair issues together
    step(2'b11, mk(32'h200, 6, 1, 2, 0, 0), mk(32'h204, 9, 7, 8, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    // 3: branch waits for its delay slot
    step(2'b01, z, mk(32'h300, 0, 1, 2, 1, 0), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    step(2'b01, z, mk(32'h304, 10, 3, 3, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    // 4: two loads, then two stores, one memory port
    step(2'b11, mk(32'h400, 11, 1, 0, 0, 1), mk(32'h404, 12, 2, 0, 0, 1), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);
    step(2'b11, mk(32'h410, 0, 1, 13, 0, 1), mk(32'h414, 0, 2, 14, 0, 1), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);
    // 5: fill to DEPTH-1 while stalled, hold, then drain across the wrap
    for (int i = 0; i < 3; i++)
      step(2'b11, mk(32'h500 + 8 * i, 0, 1, 2, 0, 0), mk(32'h504 + 8 * i, 0, 3, 4, 0, 0),
           1'b0, 1'b0, 1'b0);
    step(2'b01, z, mk(32'h518, 0, 5, 6, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 6);
    // 6: flush with a same-cycle push and pop
    step(2'b11, mk(32'h600, 1, 0, 0, 0, 0), mk(32'h604, 2, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    step(2'b11, mk(32'h608, 3, 2, 0, 0, 0), mk(32'h60c, 4, 3, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    step(2'b01, z, mk(32'h610, 5, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    step(2'b11, mk(32'h700, 1, 0, 0, 0, 0), mk(32'h704, 2, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);
    // reset in mid-operation
    step(2'b11, mk(32'h800, 1, 0, 0, 0, 0), mk(32'h804, 2, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    step(2'b00, z, z, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      a = rnd_ent();
      b = rnd_ent();
      v = bus.in_ready ? 2'($urandom_range(0, 3)) : 2'b00;
      step(v, a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 199) == 0);
    end
    // Drain, giving any trailing branch a delay slot
    idle(1'b1, 1);
    if (bus.in_ready) step(2'b01, z, mk(32'h900, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
